// File: rtl/exception_sequencer_pkg.sv
// Shared types and constants for the exception/return sequencer.
package exception_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SAVE,
      WAIT,
      LOAD
   } state_t;

   localparam int CAUSE_OVF  = 0;
   localparam int CAUSE_NOOP = 1;
   localparam int CAUSE_DIV0 = 2;

   localparam int DEF_VEC_BASE = 253;

endpackage

// File: rtl/exception_sequencer_prio_enc.sv
// Lowest-index-wins priority encoder for exception request lines.
module exc_prio_enc #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   output logic         any,
   output logic [W-1:0] idx
);

   always_comb begin
      any = |req;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry / RTE sequencer: saves EPC, fetches the handler
// byte from the per-cause vector slot and loads it into the PC.
module exception_sequencer
   import exception_sequencer_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int N_EXC    = 3,
   parameter int CAUSE_W  = 2,
   parameter int VEC_BASE = DEF_VEC_BASE,
   parameter int MEM_WAIT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_EXC-1:0]  exc_req,
   input  logic              rte_req,
   input  logic [DATA_W-1:0] pc_cur,
   input  logic [7:0]        mem_data,
   output logic [DATA_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              pc_write,
   output logic [DATA_W-1:0] pc_value,
   output logic [DATA_W-1:0] epc,
   output logic [CAUSE_W-1:0] cause,
   output logic [N_EXC-1:0]  exc_ack,
   output logic              rte_ack,
   output logic              busy
);

   state_t               state;
   state_t               nstate;
   logic                 enc_any;
   logic [CAUSE_W-1:0]   enc_idx;
   logic [CAUSE_W-1:0]   idx_q;
   logic [3:0]           cnt;
   logic [DATA_W-1:0]    epc_q;
   logic [CAUSE_W-1:0]   cause_q;
   logic [DATA_W-1:0]    vec_addr;

   exc_prio_enc #(
      .N (N_EXC),
      .W (CAUSE_W)
   ) u_enc (
      .req (exc_req),
      .any (enc_any),
      .idx (enc_idx)
   );

   assign vec_addr = DATA_W'(VEC_BASE) + DATA_W'(idx_q);
   assign epc      = epc_q;
   assign cause    = cause_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         idx_q   <= '0;
         cnt     <= '0;
         epc_q   <= '0;
         cause_q <= '0;
      end else begin
         state <= nstate;
         unique case (state)
            IDLE: begin
               if (enc_any) idx_q <= enc_idx;
            end
            SAVE: begin
               // pc_cur already points past the faulting instruction
               epc_q   <= pc_cur - DATA_W'(4);
               cause_q <= idx_q;
               cnt     <= 4'd1;
            end
            WAIT: begin
               if (cnt != 4'(MEM_WAIT)) cnt <= cnt + 4'd1;
            end
            LOAD: begin
               cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      nstate   = state;
      mem_addr = '0;
      mem_rd   = 1'b0;
      pc_write = 1'b0;
      pc_value = '0;
      exc_ack  = '0;
      rte_ack  = 1'b0;
      busy     = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (enc_any) begin
               nstate = SAVE;
            end else if (rte_req) begin
               pc_write = 1'b1;
               pc_value = epc_q;
               rte_ack  = 1'b1;
            end
         end
         SAVE: begin
            mem_addr = vec_addr;
            mem_rd   = 1'b1;
            nstate   = WAIT;
         end
         WAIT: begin
            mem_addr = vec_addr;
            if (cnt == 4'(MEM_WAIT)) nstate = LOAD;
         end
         LOAD: begin
            pc_value = {{(DATA_W-8){1'b0}}, mem_data};
            pc_write = 1'b1;
            exc_ack  = N_EXC'(1) << idx_q;
            nstate   = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench for exception_sequencer plus parameter sweep instances.
module tb_exception_sequencer;

   localparam int MW = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  exc_req;
   logic        rte_req;
   logic [31:0] pc_cur;
   logic [7:0]  mem_data;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        pc_write;
   logic [31:0] pc_value;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic [2:0]  exc_ack;
   logic        rte_ack;
   logic        busy;

   logic        rz = 1'b0;
   logic [7:0]  md_k = 8'h33;
   logic [31:0] pc_k = 32'h1000;

   logic [2:0]  req_w1, ack_w1;
   logic [31:0] addr_w1, pcv_w1, epc_w1;
   logic [1:0]  cause_w1;
   logic        rd_w1, pcw_w1, rack_w1, busy_w1;

   logic [2:0]  req_w15, ack_w15;
   logic [31:0] addr_w15, pcv_w15, epc_w15;
   logic [1:0]  cause_w15;
   logic        rd_w15, pcw_w15, rack_w15, busy_w15;

   logic [4:0]  req_n5, ack_n5;
   logic [31:0] addr_n5, pcv_n5, epc_n5;
   logic [2:0]  cause_n5;
   logic        rd_n5, pcw_n5, rack_n5, busy_n5;

   always #5 clk = ~clk;

   exception_sequencer #(.MEM_WAIT(MW)) dut (
      .clk(clk), .reset(reset), .exc_req(exc_req), .rte_req(rte_req),
      .pc_cur(pc_cur), .mem_data(mem_data), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .pc_write(pc_write), .pc_value(pc_value),
      .epc(epc), .cause(cause), .exc_ack(exc_ack), .rte_ack(rte_ack),
      .busy(busy)
   );

   exception_sequencer #(.MEM_WAIT(1)) dut_w1 (
      .clk(clk), .reset(reset), .exc_req(req_w1), .rte_req(rz),
      .pc_cur(pc_k), .mem_data(md_k), .mem_addr(addr_w1),
      .mem_rd(rd_w1), .pc_write(pcw_w1), .pc_value(pcv_w1),
      .epc(epc_w1), .cause(cause_w1), .exc_ack(ack_w1),
      .rte_ack(rack_w1), .busy(busy_w1)
   );

   exception_sequencer #(.MEM_WAIT(15)) dut_w15 (
      .clk(clk), .reset(reset), .exc_req(req_w15), .rte_req(rz),
      .pc_cur(pc_k), .mem_data(md_k), .mem_addr(addr_w15),
      .mem_rd(rd_w15), .pc_write(pcw_w15), .pc_value(pcv_w15),
      .epc(epc_w15), .cause(cause_w15), .exc_ack(ack_w15),
      .rte_ack(rack_w15), .busy(busy_w15)
   );

   exception_sequencer #(.N_EXC(5), .CAUSE_W(3)) dut_n5 (
      .clk(clk), .reset(reset), .exc_req(req_n5), .rte_req(rz),
      .pc_cur(pc_k), .mem_data(md_k), .mem_addr(addr_n5),
      .mem_rd(rd_n5), .pc_write(pcw_n5), .pc_value(pcv_n5),
      .epc(epc_n5), .cause(cause_n5), .exc_ack(ack_n5),
      .rte_ack(rack_n5), .busy(busy_n5)
   );

   // memory model: byte becomes valid MW cycles after the read strobe
   logic [7:0]  mem [256];
   logic [31:0] rd_a = '0;
   int          dly = 0;

   always @(posedge clk) begin
      if (mem_rd) begin
         rd_a <= mem_addr;
         dly  <= MW - 1;
      end else if (dly > 0) begin
         dly <= dly - 1;
      end
   end

   assign mem_data = (dly == 0) ? mem[rd_a[7:0]] : 8'h5A;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] pcv;
      logic [2:0]  ack;
      logic        rte;
   } exp_t;

   exp_t sbq[$];

   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && pc_write) begin
         if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
         end else begin
            e = sbq.pop_front();
            chk("sb_pc_value", pc_value, e.pcv);
            chk("sb_exc_ack", exc_ack, e.ack);
            chk("sb_rte_ack", rte_ack, e.rte);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_exc(input logic [2:0] req, input logic [31:0] pc,
                          input logic rte, input logic [31:0] vaddr,
                          input logic [31:0] pcv, input logic [2:0] ack,
                          input logic [31:0] epc_exp,
                          input logic [1:0] cause_exp);
      int n;
      exc_req = req;
      pc_cur  = pc;
      rte_req = rte;
      sbq.push_back({pcv, ack, 1'b0});
      #1;
      if (rte) chk("rte_dropped", {pc_write, rte_ack}, 0);
      step();
      rte_req = 1'b0;
      n = 1;
      chk("save_mem_rd", mem_rd, 1);
      chk("save_mem_addr", mem_addr, vaddr);
      while (!pc_write && n < 40) begin
         step();
         n++;
      end
      chk("latency", n, MW + 2);
      exc_req = exc_req & ~exc_ack;
      step();
      chk("epc", epc, epc_exp);
      chk("cause", cause, cause_exp);
      chk("idle", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[253] = 8'h80;
      mem[254] = 8'hA0;
      mem[255] = 8'hC0;
      reset   = 1'b1;
      exc_req = '0;
      rte_req = 1'b0;
      pc_cur  = '0;
      req_w1  = '0;
      req_w15 = '0;
      req_n5  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", {busy, mem_rd, pc_write, rte_ack, exc_ack}, 0);
      chk("rst_epc", epc, 0);
      chk("rst_cause", cause, 0);
      @(negedge clk);
      reset = 1'b0;
      step();

      run_exc(3'b001, 32'h108, 1'b0, 32'd253, 32'h80, 3'b001,
              32'h104, 2'd0);

      sbq.push_back({32'h104, 3'b000, 1'b1});
      rte_req = 1'b1;
      #1;
      chk("rte_ack", rte_ack, 1);
      chk("rte_pc_write", pc_write, 1);
      chk("rte_pc_value", pc_value, 32'h104);
      step();
      rte_req = 1'b0;
      #1;
      chk("rte_pulse", rte_ack, 0);

      run_exc(3'b001, 32'h200, 1'b1, 32'd253, 32'h80, 3'b001,
              32'h1FC, 2'd0);

      run_exc(3'b110, 32'h300, 1'b0, 32'd254, 32'hA0, 3'b010,
              32'h2FC, 2'd1);
      chk("held_req", exc_req, 3'b100);
      run_exc(3'b100, 32'h400, 1'b0, 32'd255, 32'hC0, 3'b100,
              32'h3FC, 2'd2);

      run_exc(3'b001, 32'h0, 1'b0, 32'd253, 32'h80, 3'b001,
              32'hFFFF_FFFC, 2'd0);

      exc_req = 3'b010;
      pc_cur  = 32'h500;
      step();
      step();
      chk("pre_rst_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_outs", {mem_rd, pc_write, rte_ack, exc_ack}, 0);
      chk("midrst_addr", mem_addr, 0);
      chk("midrst_epc", epc, 0);
      chk("midrst_cause", cause, 0);
      exc_req = '0;
      @(negedge clk);
      reset = 1'b0;
      step();

      req_w1 = 3'b001;
      n = 0;
      while (!pcw_w1 && n < 60) begin
         step();
         n++;
      end
      chk("lat_w1", n, 3);
      chk("pcv_w1", pcv_w1, 32'h33);
      req_w1 = '0;
      step();

      req_w15 = 3'b001;
      n = 0;
      while (!pcw_w15 && n < 60) begin
         step();
         n++;
      end
      chk("lat_w15", n, 17);
      req_w15 = '0;
      step();

      req_n5 = 5'b10000;
      step();
      chk("n5_mem_rd", rd_n5, 1);
      chk("n5_mem_addr", addr_n5, 32'd257);
      n = 1;
      while (!pcw_n5 && n < 60) begin
         step();
         n++;
      end
      chk("n5_ack", ack_n5, 5'b10000);
      chk("n5_cause", cause_n5, 3'd4);
      req_n5 = '0;
      step();

      chk("sb_left", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
